sample_decimator: RTL
=====================

SAMPLE_DECIMATOR -- requirements
Module: sample_decimator

Interface
REQ-001 SHALL have parameter BIT_WIDTH, default 16, meaning sample width in bits (signed two's complement).
REQ-002 SHALL have parameter FIFO_DEPTH, default 16, meaning output buffer entries (power of two, at least 2).
REQ-003 SHALL have port clk, input, 1, meaning the single clock; all logic on its rising edge.
REQ-004 SHALL have port sclr, input, 1, meaning reset; synchronous, active-high.
REQ-005 SHALL have port dec_sel, input, 3, meaning decimation ratio select.
REQ-006 SHALL have port d, input, BIT_WIDTH signed, meaning filtered sample from the averaging filter output q.
REQ-007 SHALL have port d_valid, input, 1, meaning d holds a new sample this cycle.
REQ-008 SHALL have port q, output, BIT_WIDTH signed, meaning FIFO head sample.
REQ-009 SHALL have port q_valid, output, 1, meaning q is valid (FIFO not empty).
REQ-010 SHALL have port q_ready, input, 1, meaning consumer accepts q this cycle.
REQ-011 SHALL have port fifo_level, output, clog2(FIFO_DEPTH)+1, meaning current FIFO occupancy.
REQ-012 SHALL have port overflow, output, 1, meaning sticky flag: a kept sample was dropped.

Function
REQ-013 SHALL decode ratio R from dec_sel: 000 gives 1, 001 gives 2, 010 gives 4, 011 gives 8, 100 to 111 give 16 (matches filter window per select).
REQ-014 SHALL hold a phase counter in range 0 to R-1, advanced only on d_valid cycles.
REQ-015 SHALL mark a d_valid sample as kept when phase equals R-1, then wrap phase to 0; otherwise increment phase by 1.
REQ-016 SHALL pass a kept sample unmodified (no scaling, no truncation) into the FIFO.
REQ-017 SHALL register dec_sel internally; on any change of dec_sel vs the registered copy, set phase to 0 on that edge and discard that cycle's d_valid sample (not kept).
REQ-018 SHALL make a pushed sample visible at q with q_valid high on the cycle after the push edge (1-cycle latency, first-word-fall-through).
REQ-019 SHALL pop the head on every edge where q_valid and q_ready are both 1; q and q_valid SHALL stay stable while q_valid is 1 and q_ready is 0.
REQ-020 SHALL, when the FIFO is not full, push a kept sample and increment fifo_level, unless a pop occurs on the same edge (then level is unchanged).
REQ-021 SHALL, when the FIFO is full and a pop occurs on the same edge, accept the kept sample; fifo_level stays FIFO_DEPTH.
REQ-022 SHALL, when the FIFO is full and no pop occurs, drop the kept sample, leave contents unchanged, and set overflow to 1 until sclr.
REQ-023 SHALL keep q_valid at 0 while empty and ignore q_ready while empty; push into an empty FIFO with q_ready high SHALL not pop on that edge.
REQ-024 SHALL wrap read/write pointers modulo FIFO_DEPTH with no loss of ordering (strict FIFO order).

Reset
REQ-025 SHALL, on sclr high at an edge, set phase 0, FIFO empty, fifo_level 0, q_valid 0, q 0, overflow 0, and registered dec_sel to the current dec_sel.
REQ-026 SHALL, on sclr mid-operation, discard all buffered samples; a d_valid during sclr SHALL be ignored.
REQ-027 SHALL resume normal operation on the first edge with sclr low, with phase counting from 0.

Structure
REQ-028 SHALL place BIT_WIDTH default, the ratio decode function (dec_sel to R) and the dec_sel encodings in a shared package, also used by the filter.
REQ-029 SHALL implement buffering in one sub-module, sync_fifo (parameters BIT_WIDTH, FIFO_DEPTH; push/pop/full/empty/level); decimation control stays in the top.

Verification
REQ-030 SHALL cover: dec_sel=000, d_valid held 1, d=1,2,3 -> q sequence 1,2,3 with q_ready high, each appearing 1 cycle after input.
REQ-031 SHALL cover: dec_sel=010, d=10..17 on consecutive d_valid -> only 13 and 17 pushed; fifo_level reaches 2 with q_ready low.
REQ-032 SHALL cover: dec_sel=000, q_ready low, 17 samples 0..16 -> fifo_level 16, sample 16 dropped, overflow 1; drain gives 0..15 in order.
REQ-033 SHALL cover: FIFO full, q_ready high, and a kept sample on the same edge -> sample accepted, fifo_level stays 16, overflow stays 0.
REQ-034 SHALL cover: dec_sel=011, 5 samples, then dec_sel changed to 001 -> phase resets; the next kept sample is the 2nd d_valid after the change edge.
REQ-035 SHALL cover: 5 entries buffered and overflow 1, then sclr for 1 cycle -> q_valid 0, fifo_level 0, overflow 0, q 0 on the next cycle.

Source files
------------

// File: rtl/sample_decimator_pkg.sv
// Shared definitions for the decimator and the averaging filter that feeds it.
//   DEFAULT_BIT_WIDTH : default sample width (signed two's complement)
//   PHASE_W           : width of the decimation phase counter (covers R up to 16)
//   dec_sel_e         : encodings of the 3-bit decimation / filter-window select
//   ratio_from_sel()  : dec_sel -> ratio R (1, 2, 4, 8, 16)
//   last_phase()      : dec_sel -> R-1, the phase on which a sample is kept
package sample_decimator_pkg;

    localparam int DEFAULT_BIT_WIDTH = 16;
    localparam int PHASE_W           = 4;

    typedef enum logic [2:0] {
        DEC_SEL_1  = 3'b000,
        DEC_SEL_2  = 3'b001,
        DEC_SEL_4  = 3'b010,
        DEC_SEL_8  = 3'b011,
        DEC_SEL_16 = 3'b100
    } dec_sel_e;

    // Codes 100..111 all select the largest ratio.
    function automatic logic [4:0] ratio_from_sel(input logic [2:0] sel);
        logic [4:0] r;
        r = 5'd16;
        if (sel == DEC_SEL_1)      r = 5'd1;
        else if (sel == DEC_SEL_2) r = 5'd2;
        else if (sel == DEC_SEL_4) r = 5'd4;
        else if (sel == DEC_SEL_8) r = 5'd8;
        return r;
    endfunction

    function automatic logic [PHASE_W-1:0] last_phase(input logic [2:0] sel);
        logic [4:0] r_m1;
        r_m1 = ratio_from_sel(sel) - 5'd1;
        return r_m1[PHASE_W-1:0];
    endfunction

endpackage

// File: rtl/sample_decimator_if.sv
// Sample stream bundle around the decimator.
//   d, d_valid : incoming filtered samples
//   q, q_valid : buffered output stream (head of the output FIFO)
//   q_ready    : consumer accepts q this cycle
// Modports: master = stream source / consumer side, slave = decimator side.
interface sample_decimator_if
    import sample_decimator_pkg::*;
#(
    parameter int BIT_WIDTH = DEFAULT_BIT_WIDTH
) ();

    logic signed [BIT_WIDTH-1:0] d;
    logic                        d_valid;
    logic signed [BIT_WIDTH-1:0] q;
    logic                        q_valid;
    logic                        q_ready;

    modport master (output d, d_valid, q_ready, input q, q_valid);
    modport slave  (input d, d_valid, q_ready, output q, q_valid);

endinterface

// File: rtl/sample_decimator_sync_fifo.sv
// sync_fifo: first-word-fall-through FIFO with a registered head.
//   clk, srst  : clock, synchronous active-high reset
//   push_i     : write wr_data_i (ignored when full unless popping on the same edge)
//   wr_data_i  : sample to write
//   pop_i      : remove head (ignored when empty)
//   rd_data_o  : head sample, registered, 0 after reset
//   full_o, empty_o, level_o : occupancy status
module sync_fifo #(
    parameter int BIT_WIDTH  = 16,
    parameter int FIFO_DEPTH = 16,
    localparam int PTR_W     = $clog2(FIFO_DEPTH),
    localparam int LEVEL_W   = PTR_W + 1
) (
    input  logic                        clk,
    input  logic                        srst,
    input  logic                        push_i,
    input  logic signed [BIT_WIDTH-1:0] wr_data_i,
    input  logic                        pop_i,
    output logic signed [BIT_WIDTH-1:0] rd_data_o,
    output logic                        full_o,
    output logic                        empty_o,
    output logic [LEVEL_W-1:0]          level_o
);

    logic signed [BIT_WIDTH-1:0] mem [FIFO_DEPTH];

    logic [PTR_W-1:0]            wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]            rd_ptr_q, rd_ptr_d;
    logic [LEVEL_W-1:0]          count_q, count_d;
    logic signed [BIT_WIDTH-1:0] head_q, head_d;
    logic                        do_push, do_pop;

    assign full_o    = (count_q == LEVEL_W'(FIFO_DEPTH));
    assign empty_o   = (count_q == '0);
    assign level_o   = count_q;
    assign rd_data_o = head_q;

    // A full FIFO still accepts a write when the head leaves on the same edge.
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        head_d   = head_q;
        if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
        if (do_push && !do_pop)      count_d = count_q + 1'b1;
        else if (!do_push && do_pop) count_d = count_q - 1'b1;
        // Head register: new data bypasses the array when it becomes the
        // head immediately; otherwise the next entry is read from the array.
        // When full, the write slot equals the old head slot, never rd_ptr+1.
        if (do_push && (empty_o || (do_pop && count_q == LEVEL_W'(1))))
            head_d = wr_data_i;
        else if (do_pop && count_q > LEVEL_W'(1))
            head_d = mem[rd_ptr_d];
    end

    always_ff @(posedge clk) begin
        if (!srst && do_push)
            mem[wr_ptr_q] <= wr_data_i;
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            head_q   <= head_d;
        end
    end

endmodule

// File: rtl/sample_decimator.sv
// sample_decimator: keeps one of every R valid samples (R from dec_sel) and
// buffers the kept samples in an output FIFO.
//   clk        : clock, rising edge
//   sclr       : synchronous active-high reset
//   dec_sel    : decimation ratio select (1/2/4/8/16)
//   bus        : sample stream (d/d_valid in, q/q_valid/q_ready out)
//   fifo_level : output FIFO occupancy
//   overflow   : sticky, a kept sample was dropped because the FIFO was full
module sample_decimator
    import sample_decimator_pkg::*;
#(
    parameter int BIT_WIDTH  = DEFAULT_BIT_WIDTH,
    parameter int FIFO_DEPTH = 16,
    localparam int LEVEL_W   = $clog2(FIFO_DEPTH) + 1
) (
    input  logic               clk,
    input  logic               sclr,
    input  logic [2:0]         dec_sel,
    sample_decimator_if.slave  bus,
    output logic [LEVEL_W-1:0] fifo_level,
    output logic               overflow
);

    logic [2:0]         dec_sel_q;
    logic [PHASE_W-1:0] phase_q, phase_d;
    logic               overflow_q, overflow_d;
    logic               sel_changed, keep, pop, fifo_full, fifo_empty;

    assign sel_changed = (dec_sel != dec_sel_q);
    assign pop         = bus.q_ready && !fifo_empty;
    assign bus.q_valid = !fifo_empty;
    assign overflow    = overflow_q;

    // A ratio change restarts the phase and throws away that cycle's sample,
    // so the first kept sample after a change always uses the new ratio.
    always_comb begin
        phase_d    = phase_q;
        keep       = 1'b0;
        if (sel_changed) begin
            phase_d = '0;
        end else if (bus.d_valid) begin
            if (phase_q == last_phase(dec_sel_q)) begin
                keep    = 1'b1;
                phase_d = '0;
            end else begin
                phase_d = phase_q + 1'b1;
            end
        end
        overflow_d = overflow_q | (keep && fifo_full && !pop);
    end

    always_ff @(posedge clk) begin
        if (sclr) begin
            dec_sel_q  <= dec_sel;
            phase_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            dec_sel_q  <= dec_sel;
            phase_q    <= phase_d;
            overflow_q <= overflow_d;
        end
    end

    sync_fifo #(
        .BIT_WIDTH  (BIT_WIDTH),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .srst      (sclr),
        .push_i    (keep),
        .wr_data_i (bus.d),
        .pop_i     (pop),
        .rd_data_o (bus.q),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .level_o   (fifo_level)
    );

endmodule
